// File: rtl/inst_issue_queue.sv
// Fetch-to-decode instruction queue: compacts enabled fetch lanes into a circular buffer and presents
// the oldest ISSUE_W entries. Optional perf counters are enabled with the IQ_PERF_CNT_EN macro.
module inst_issue_queue #(
    parameter int FETCH_W     = 4,
    parameter int ISSUE_W     = 2,
    parameter int DEPTH       = 16,
    parameter int INST_W      = 32,
    parameter int META_W      = 40,
    parameter int STOP_MARGIN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [FETCH_W-1:0]           in_enable_i,
    input  logic [31:0]                  in_base_pc_i,
    input  logic [FETCH_W*INST_W-1:0]    in_inst_i,
    input  logic [FETCH_W*META_W-1:0]    in_meta_i,
    output logic                         stop_fetch_o,
    output logic [ISSUE_W-1:0]           out_valid_o,
    output logic [ISSUE_W*32-1:0]        out_pc_o,
    output logic [ISSUE_W*INST_W-1:0]    out_inst_o,
    output logic [ISSUE_W*META_W-1:0]    out_meta_o,
    input  logic [$clog2(ISSUE_W+1)-1:0] deq_num_i,
    output logic [$clog2(DEPTH):0]       count_o
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_full_cyc_o,
    output logic [31:0]                  perf_empty_cyc_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Number of enabled lanes strictly below 'lane' = slot offset of that lane from tail.
    function automatic logic [PW-1:0] lane_offset(input logic [FETCH_W-1:0] en, input int lane);
        logic [PW-1:0] acc;
        acc = {PW{1'b0}};
        for (int j = 0; j < FETCH_W; j++) begin
            if (j < lane) begin
                acc = acc + {{(PW-1){1'b0}}, en[j]};
            end
        end
        return acc;
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [FETCH_W-1:0] en);
        logic [CW-1:0] acc;
        acc = {CW{1'b0}};
        for (int j = 0; j < FETCH_W; j++) begin
            acc = acc + {{(CW-1){1'b0}}, en[j]};
        end
        return acc;
    endfunction

    logic [31:0]     pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic [META_W-1:0] meta_mem_r [DEPTH];

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          fire_s;
    logic          wr_en_s;
    logic [CW-1:0] free_s;
    logic [CW-1:0] enq_num_s;
    logic [CW-1:0] deq_req_s;
    logic [CW-1:0] deq_n_s;
    logic [PW-1:0] wr_idx_s [FETCH_W];

    // Occupancy-derived handshakes, clamped dequeue and per-lane write slots.
    always_comb begin
        free_s       = CW'(DEPTH) - count_r;
        in_ready_o   = (free_s >= CW'(FETCH_W));
        stop_fetch_o = (free_s < CW'(STOP_MARGIN));
        fire_s       = in_valid_i & in_ready_o;
        wr_en_s      = fire_s & rst & ~flush_i;
        enq_num_s    = fire_s ? popcnt(in_enable_i) : {CW{1'b0}};
        deq_req_s    = CW'(deq_num_i);
        if (deq_req_s > count_r) begin
            deq_n_s = count_r;
        end else begin
            deq_n_s = deq_req_s;
        end
        for (int i = 0; i < FETCH_W; i++) begin
            wr_idx_s[i] = tail_r + lane_offset(in_enable_i, i);
        end
    end

    // Pointer and occupancy update; reset and flush both drop everything.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_r + deq_n_s[PW-1:0];
            tail_r  <= tail_r + enq_num_s[PW-1:0];
            count_r <= count_r + enq_num_s - deq_n_s;
        end
    end

    // Entry storage; contents survive reset and flush, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (in_enable_i[i]) begin
                    pc_mem_r[wr_idx_s[i]]   <= in_base_pc_i + 32'(4 * i);
                    inst_mem_r[wr_idx_s[i]] <= in_inst_i[i*INST_W +: INST_W];
                    meta_mem_r[wr_idx_s[i]] <= in_meta_i[i*META_W +: META_W];
                end
            end
        end
    end

    // Issue window: oldest entries first, read straight from registered state.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid_o[k]                  = (count_r > CW'(k));
            out_pc_o[k*32 +: 32]            = pc_mem_r[head_r + PW'(k)];
            out_inst_o[k*INST_W +: INST_W]  = inst_mem_r[head_r + PW'(k)];
            out_meta_o[k*META_W +: META_W]  = meta_mem_r[head_r + PW'(k)];
        end
        count_o = count_r;
    end

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_full_r;
    logic [31:0] perf_empty_r;

    // Saturating stall/idle counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_full_r  <= 32'd0;
            perf_empty_r <= 32'd0;
        end else begin
            if (!in_ready_o && (perf_full_r != 32'hFFFF_FFFF)) begin
                perf_full_r <= perf_full_r + 32'd1;
            end
            if ((count_r == {CW{1'b0}}) && (perf_empty_r != 32'hFFFF_FFFF)) begin
                perf_empty_r <= perf_empty_r + 32'd1;
            end
        end
    end

    assign perf_full_cyc_o  = perf_full_r;
    assign perf_empty_cyc_o = perf_empty_r;
`endif

endmodule
